fmul_arbiter: RTL

Round-robin arbiter and sequencer that shares one fully pipelined 64-bit IEEE-754 multiplier (`FLOAT_MUL`) among `NREQ` requesters. It accepts at most one operand pair per cycle and registers it onto the multiplier inputs. A requester-ID tag travels through a shift register alongside the multiplier pipeline. Each result is routed back to the requester that issued it. A per-requester outstanding-operation limit is enforced.

---
 rtl/fmul_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fmul_arbiter.sv
// Round-robin front end that shares one pipelined floating-point multiplier among NREQ requesters.
// A requester-ID tag rides alongside the multiplier pipeline so each result returns to its issuer.
module fmul_arbiter #(
  parameter int NREQ      = 4,
  parameter int BIT       = 64,
  parameter int LAT       = 14,
  parameter int MAX_OUTST = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BIT-1:0]  req_num1,
  input  logic [NREQ*BIT-1:0]  req_num2,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [BIT-1:0]       rsp_result,
  output logic                 mul_valid,
  output logic [BIT-1:0]       mul_num1,
  output logic [BIT-1:0]       mul_num2,
  input  logic [BIT-1:0]       mul_result,
  input  logic                 mul_ready,
  output logic                 busy,
  output logic                 err
);

  localparam int IW    = $clog2(NREQ);
  localparam int CW    = 4;
  // Tail lines up with mul_ready, which arrives LAT edges after the issue edge.
  localparam int DEPTH = LAT + 1;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_id;
  logic            found;
  logic [IW:0]     sum;
  logic [IW-1:0]   idx;
  logic            accept;
  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   rr_d;
  logic [BIT-1:0]  sel1;
  logic [BIT-1:0]  sel2;

  logic [CW-1:0]   cnt_q [NREQ];
  logic            mul_valid_q;
  logic [BIT-1:0]  num1_q;
  logic [BIT-1:0]  num2_q;
  logic [IW-1:0]   id_q;
  logic [DEPTH-1:0] tag_v_q;
  logic [IW-1:0]   tag_id_q [DEPTH];
  logic            err_q;

  logic            tail_v;
  logic [IW-1:0]   tail_id;

  assign tail_v  = tag_v_q[DEPTH-1];
  assign tail_id = tag_id_q[DEPTH-1];

  // A strobing response frees its slot in the same cycle, so eligibility sees the decrement.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign rsp_valid[gi] = mul_ready & tail_v & (tail_id == IW'(gi));
    assign elig[gi]      = req_valid[gi] &
                           ((cnt_q[gi] - CW'(rsp_valid[gi])) < CW'(MAX_OUTST));
  end

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (!found && elig[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
    if (!rstn) begin
      grant    = '0;
      grant_id = '0;
    end
  end

  always_comb begin
    sel1 = '0;
    sel2 = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        sel1 = req_num1[k*BIT +: BIT];
        sel2 = req_num2[k*BIT +: BIT];
      end
    end
  end

  assign accept = |grant;
  assign rr_d   = (grant_id == IW'(NREQ-1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (grant[k] && !rsp_valid[k])      cnt_q[k] <= cnt_q[k] + 1'b1;
        else if (!grant[k] && rsp_valid[k]) cnt_q[k] <= cnt_q[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mul_valid_q <= 1'b0;
      num1_q      <= '0;
      num2_q      <= '0;
      id_q        <= '0;
      rr_q        <= '0;
      tag_v_q     <= '0;
      for (int k = 0; k < DEPTH; k++) tag_id_q[k] <= '0;
      err_q       <= 1'b0;
    end else begin
      mul_valid_q <= accept;
      if (accept) begin
        num1_q <= sel1;
        num2_q <= sel2;
        id_q   <= grant_id;
        rr_q   <= rr_d;
      end
      tag_v_q     <= {tag_v_q[DEPTH-2:0], mul_valid_q};
      tag_id_q[0] <= id_q;
      for (int k = 1; k < DEPTH; k++) tag_id_q[k] <= tag_id_q[k-1];
      // Any result strobe not matching an expected tag is a sticky protocol fault.
      err_q <= err_q | (mul_ready ^ tail_v);
    end
  end

  assign req_ready  = grant;
  assign mul_valid  = mul_valid_q;
  assign mul_num1   = num1_q;
  assign mul_num2   = num2_q;
  assign rsp_result = mul_result;
  assign busy       = mul_valid_q | (|tag_v_q);
  assign err        = err_q;

endmodule
